ip2dma_stream_arbiter: RTL

Packet-granular round-robin arbiter that shares the single 128-bit MM2S AXI-Stream path toward the DMA between NUM_IN producer IPs. Each producer presents the ip-side stream bundle (dout/valid/ready/keep/last). A granted producer holds the path until its last beat. A single registered output stage drives m_axis_mm2s_* at full throughput.

---
 rtl/ip2dma_stream_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/ip2dma_stream_arbiter.sv
// ip2dma_stream_arbiter: packet-granular round-robin arbiter. It merges
// NUM_IN producer streams onto the single MM2S AXI-Stream path to the DMA.
// A granted producer owns the path until its last beat. The output is one
// registered stage that sustains one beat per cycle inside a packet.
module ip2dma_stream_arbiter #(
  parameter int NUM_IN = 4,
  parameter int DATA_W = 128,
  parameter int KEEP_W = DATA_W / 8,
  parameter int ID_W   = 2
) (
  input  logic                     m_axis_mm2s_aclk,
  input  logic                     reset,
  input  logic [NUM_IN*DATA_W-1:0] s_dout,
  input  logic [NUM_IN-1:0]        s_valid,
  output logic [NUM_IN-1:0]        s_ready,
  input  logic [NUM_IN*KEEP_W-1:0] s_keep,
  input  logic [NUM_IN-1:0]        s_last,
  output logic [DATA_W-1:0]        m_axis_mm2s_tdata,
  output logic [KEEP_W-1:0]        m_axis_mm2s_tkeep,
  output logic                     m_axis_mm2s_tlast,
  output logic                     m_axis_mm2s_tvalid,
  input  logic                     m_axis_mm2s_tready,
  output logic [ID_W-1:0]          m_src_id,
  output logic                     busy,
  output logic [31:0]              pkt_count
);

  typedef enum logic {IDLE, PKT} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   ptr, ptr_nxt;       // last input served; scan starts after it
  logic [ID_W-1:0]   grant, grant_nxt;   // input owning the path while in PKT
  logic              scan_found;
  logic [ID_W-1:0]   scan_sel;
  int                scan_idx;
  logic              sel_valid, sel_last;
  logic [DATA_W-1:0] sel_data;
  logic [KEEP_W-1:0] sel_keep;
  logic              load_ok, accept;

  // The output register can take a new beat when empty or draining this cycle.
  assign load_ok = !m_axis_mm2s_tvalid || m_axis_mm2s_tready;
  assign busy    = (state == PKT);

  // Round-robin scan: first valid input at ptr+1, ptr+2, ... modulo NUM_IN.
  // NOTE: every variable driven here gets a default before any branch, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    scan_found = 1'b0;
    scan_sel   = ptr;
    scan_idx   = 0;
    for (int k = 1; k <= NUM_IN; k++) begin
      scan_idx = int'(ptr) + k;
      if (scan_idx >= NUM_IN) scan_idx = scan_idx - NUM_IN;
      for (int i = 0; i < NUM_IN; i++) begin
        if (!scan_found && scan_idx == i && s_valid[i]) begin
          scan_found = 1'b1;
          scan_sel   = ID_W'(i);
        end
      end
    end
  end

  // Mux the granted producer's beat; a compare loop keeps every index constant.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_keep  = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant == ID_W'(i)) begin
        sel_valid = s_valid[i];
        sel_last  = s_last[i];
        sel_data  = s_dout[i*DATA_W +: DATA_W];
        sel_keep  = s_keep[i*KEEP_W +: KEEP_W];
      end
    end
  end

  // Next-state, grant/pointer update and producer ready generation.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    ptr_nxt   = ptr;
    s_ready   = '0;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        // Arbitration takes this whole cycle; nothing is accepted here.
        if (scan_found) begin
          grant_nxt = scan_sel;
          state_nxt = PKT;
        end
      end
      PKT: begin
        // Grant is held even while s_valid[grant] is low mid-packet.
        for (int i = 0; i < NUM_IN; i++) begin
          if (grant == ID_W'(i)) s_ready[i] = load_ok;
        end
        accept = sel_valid && load_ok;
        if (accept && sel_last) begin
          state_nxt = IDLE;
          ptr_nxt   = grant;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state register; reset leaves input 0 with top priority.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge m_axis_mm2s_aclk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= ID_W'(NUM_IN - 1);
      grant <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      grant <= grant_nxt;
    end
  end

  // Output register stage and downstream packet counter.
  // NOTE: the data registers are reset as well, because zero tdata/tkeep is
  // visible on the port after reset rather than a don't-care.
  always_ff @(posedge m_axis_mm2s_aclk) begin
    if (reset) begin
      m_axis_mm2s_tvalid <= 1'b0;
      m_axis_mm2s_tdata  <= '0;
      m_axis_mm2s_tkeep  <= '0;
      m_axis_mm2s_tlast  <= 1'b0;
      m_src_id           <= '0;
      pkt_count          <= '0;
    end else begin
      if (accept) begin
        m_axis_mm2s_tvalid <= 1'b1;
        m_axis_mm2s_tdata  <= sel_data;
        m_axis_mm2s_tkeep  <= sel_keep;
        m_axis_mm2s_tlast  <= sel_last;
        m_src_id           <= grant;
      end else if (m_axis_mm2s_tvalid && m_axis_mm2s_tready) begin
        m_axis_mm2s_tvalid <= 1'b0;
      end
      if (m_axis_mm2s_tvalid && m_axis_mm2s_tready && m_axis_mm2s_tlast) begin
        pkt_count <= pkt_count + 32'd1;
      end
    end
  end

endmodule
